// File: rtl/pythag_leg_solver.sv
// Recovers the missing leg b = sqrt(c^2 - a^2) with shift-add squaring and a restoring bitwise sqrt.
// Optional rounding to nearest under `define PYTHAG_ROUND_EN; the default build returns floor(sqrt).
module pythag_leg_solver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] hyp,
    input  logic [WIDTH-1:0] leg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] other_leg,
    output logic             err,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, SQ_HYP, SQ_LEG, SQRT, DONE} state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [WIDTH-1:0]    leg_q;
    logic [WIDTH-1:0]    mplr_q;
    logic [2*WIDTH-1:0]  mcand_q;
    logic [2*WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]    root_q;
    logic [WIDTH+1:0]    rem_q;
    logic [WIDTH-1:0]    other_leg_q;
    logic                out_valid_q;
    logic                err_q;

    logic                last_c;
    logic [2*WIDTH-1:0]  pp_c;
    logic [WIDTH+2:0]    rem_sh_c;
    logic [WIDTH+2:0]    trial_c;
    logic [WIDTH+2:0]    diff_c;
    logic                ge_c;
    logic [WIDTH+1:0]    rem_d;
    logic [WIDTH-1:0]    root_d;
    logic [WIDTH-1:0]    result_d;

    assign last_c = (cnt_q == CW'(WIDTH - 1));
    assign pp_c   = mplr_q[0] ? mcand_q : '0;

    // One sqrt step: bring down the next two bits of D and try subtracting 4r+1.
    // diff_c cannot leave the signed range of WIDTH+3 bits, so its MSB is the borrow.
    assign rem_sh_c = {rem_q[WIDTH:0], acc_q[2*WIDTH-1 -: 2]};
    assign trial_c  = {1'b0, root_q, 2'b01};
    assign diff_c   = rem_sh_c - trial_c;
    assign ge_c     = ~diff_c[WIDTH+2];
    assign rem_d    = ge_c ? diff_c[WIDTH+1:0] : rem_sh_c[WIDTH+1:0];
    assign root_d   = {root_q[WIDTH-2:0], ge_c};

`ifdef PYTHAG_ROUND_EN
    assign result_d = (rem_d > {2'b00, root_d}) ? root_d + WIDTH'(1) : root_d;
`else
    assign result_d = root_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            leg_q       <= '0;
            mplr_q      <= '0;
            mcand_q     <= '0;
            acc_q       <= '0;
            root_q      <= '0;
            rem_q       <= '0;
            other_leg_q <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        leg_q   <= leg;
                        mcand_q <= {{WIDTH{1'b0}}, hyp};
                        mplr_q  <= hyp;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        if (leg > hyp) begin
                            // out_valid rises on the following edge, from DONE itself
                            state_q     <= DONE;
                            err_q       <= 1'b1;
                            other_leg_q <= '0;
                        end else begin
                            state_q <= SQ_HYP;
                        end
                    end
                end
                SQ_HYP: begin
                    acc_q <= acc_q + pp_c;
                    if (last_c) begin
                        mcand_q <= {{WIDTH{1'b0}}, leg_q};
                        mplr_q  <= leg_q;
                        cnt_q   <= '0;
                        state_q <= SQ_LEG;
                    end else begin
                        mcand_q <= mcand_q << 1;
                        mplr_q  <= mplr_q >> 1;
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                SQ_LEG: begin
                    // Subtracting a's partial products from c^2 never underflows since a <= c.
                    acc_q   <= acc_q - pp_c;
                    mcand_q <= mcand_q << 1;
                    mplr_q  <= mplr_q >> 1;
                    if (last_c) begin
                        root_q  <= '0;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= SQRT;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                SQRT: begin
                    acc_q  <= acc_q << 2;
                    rem_q  <= rem_d;
                    root_q <= root_d;
                    if (last_c) begin
                        other_leg_q <= result_d;
                        err_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign other_leg = other_leg_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pythag_leg_solver.sv
// Randomised and directed requests against an arithmetic model of the missing-leg solver.
module tb_pythag_leg_solver;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] hyp;
    logic [W-1:0] leg;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] other_leg;
    logic         err;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pythag_leg_solver #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .hyp       (hyp),
        .leg       (leg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .other_leg (other_leg),
        .err       (err),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Closest integer to sqrt(c^2 - a^2), or the floor when rounding is off.
    function automatic int model_leg(input int c, input int a);
        int d;
        int r;
        if (a > c) return 0;
        d = c * c - a * a;
        r = 0;
        while ((r + 1) * (r + 1) <= d) r++;
`ifdef PYTHAG_ROUND_EN
        if ((r + 1) * (r + 1) - d < d - r * r) r++;
`endif
        return r;
    endfunction

    task automatic run_req(input int c, input int a, input int hold, input string tag);
        int lat;
        int exp_leg;
        int exp_lat;
        logic [W-1:0] held_leg;
        exp_leg = model_leg(c, a);
        exp_lat = (a > c) ? 1 : 3 * W;
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        check({tag, ".ready"}, in_ready, 1);
        in_valid = 1'b1;
        hyp      = W'(c);
        leg      = W'(a);
        @(negedge clk);
        in_valid = 1'b0;
        hyp      = W'($urandom);
        leg      = W'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"}, lat, exp_lat);
        check({tag, ".leg"}, other_leg, exp_leg);
        check({tag, ".err"}, err, (a > c) ? 1 : 0);
        check({tag, ".busy"}, busy, 1);
        held_leg = other_leg;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            hyp      = W'($urandom);
            leg      = W'($urandom);
            @(negedge clk);
            check({tag, ".hold_vld"}, out_valid, 1);
            check({tag, ".hold_leg"}, other_leg, held_leg);
            check({tag, ".hold_rdy"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".vld_drop"}, out_valid, 0);
        check({tag, ".idle"}, in_ready, 1);
        check({tag, ".keep"}, other_leg, exp_leg);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        hyp       = '0;
        leg       = '0;
        repeat (3) @(negedge clk);
        check("rst.in_ready", in_ready, 1);
        check("rst.out_valid", out_valid, 0);
        check("rst.busy", busy, 0);
        check("rst.leg", other_leg, 0);
        check("rst.err", err, 0);
        rst = 1'b0;
        @(negedge clk);

        run_req(5, 3, 0, "p345");
        run_req(255, 0, 0, "leg0");
        run_req(13, 12, 1, "p5_12_13");
        run_req(9, 9, 0, "equal");
        run_req(3, 5, 0, "errcase");
        run_req(5, 2, 0, "d21");
        run_req(10, 9, 0, "d19");
        run_req(255, 254, 2, "big");
        run_req(200, 120, 10, "stall");
        run_req(17, 8, 0, "after_stall");

        // Reset while squaring the known leg
        in_valid = 1'b1;
        hyp      = W'(20);
        leg      = W'(16);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        check("mid.busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid.in_ready", in_ready, 1);
        check("mid.out_valid", out_valid, 0);
        check("mid.leg", other_leg, 0);
        check("mid.err", err, 0);
        check("mid.busy", busy, 0);
        run_req(8, 6, 0, "post_rst");

        for (int n = 0; n < 30; n++) begin
            int c;
            int a;
            c = int'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) a = int'($urandom_range(0, 255));
            else a = int'($urandom_range(0, c));
            run_req(c, a, int'($urandom_range(0, 3)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
